// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: RLE word fields, the pixel type and the
// decompressor state encoding.
package fb_pkg;

  localparam int unsigned RUN_MSB              = 15;
  localparam int unsigned RUN_LSB              = 12;
  localparam int unsigned COLOR_MSB            = 11;
  localparam int unsigned FRAME_PIXELS_DEFAULT = 57600;

  typedef logic [COLOR_MSB:0]       pixel_t;
  typedef logic [RUN_MSB-RUN_LSB:0] run_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_EMIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/rle_decompress_if.sv
// SPRAM read port plus RGB444 pixel stream between the decompressor (master)
// and the memory/display side (slave).
interface rle_decompress_if #(
  parameter int unsigned ADDR_W = 14
);
  import fb_pkg::*;

  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rdata;
  pixel_t            pix_data;
  logic              pix_valid;
  logic              pix_ready;

  modport master (
    output mem_rd, mem_addr, pix_data, pix_valid,
    input  mem_rdata, pix_ready
  );

  modport slave (
    input  mem_rd, mem_addr, pix_data, pix_valid,
    output mem_rdata, pix_ready
  );

endinterface

// File: rtl/rle_decompress.sv
// Run-length decoder: fetches 16-bit RLE words from SPRAM and streams one
// frame of RGB444 pixels, then pulses decompress_finish.
module rle_decompress
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 14,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned MAX_WORDS    = 16384,
  parameter int unsigned FRAME_PIXELS = FRAME_PIXELS_DEFAULT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             decompress_start,
  output logic             decompress_finish,
  output logic             busy,
  rle_decompress_if.master bus,
  output logic             err_overrun,
  output logic             err_budget
);

  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   WORD_LIMIT = (ADDR_W+1)'(MAX_WORDS);
  localparam logic [15:0]       FRAME_END  = 16'(FRAME_PIXELS);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [15:0]       pix_q, pix_d;
  run_t              run_q, run_d;
  pixel_t            color_q, color_d;
  logic              ovr_q, ovr_d;
  logic              bud_q, bud_d;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= BASE;
      words_q <= '0;
      pix_q   <= '0;
      run_q   <= '0;
      color_q <= '0;
      ovr_q   <= 1'b0;
      bud_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      pix_q   <= pix_d;
      run_q   <= run_d;
      color_q <= color_d;
      ovr_q   <= ovr_d;
      bud_q   <= bud_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    words_d = words_q;
    pix_d   = pix_q;
    run_d   = run_q;
    color_d = color_q;
    ovr_d   = ovr_q;
    bud_d   = bud_q;

    unique case (state_q)
      ST_IDLE: begin
        if (decompress_start) begin
          state_d = ST_FETCH;
          addr_d  = BASE;
          words_d = '0;
          pix_d   = '0;
          ovr_d   = 1'b0;
          bud_d   = 1'b0;
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        run_d   = bus.mem_rdata[RUN_MSB:RUN_LSB];
        color_d = bus.mem_rdata[COLOR_MSB:0];
        addr_d  = addr_q + 1'b1;
        words_d = words_q + 1'b1;
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (bus.pix_ready) begin
          pix_d = pix_q + 16'd1;
          run_d = run_q - 1'b1;
          // Frame end wins over run end; a non-zero residual run means truncation.
          if (pix_d == FRAME_END) begin
            ovr_d   = ovr_q | (run_q != '0);
            state_d = ST_DONE;
          end else if (run_q == '0) begin
            if (words_q == WORD_LIMIT) begin
              bud_d   = 1'b1;
              state_d = ST_DONE;
            end else begin
              state_d = ST_FETCH;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.mem_rd        = (state_q == ST_FETCH);
  assign bus.mem_addr      = addr_q;
  assign bus.pix_valid     = (state_q == ST_EMIT);
  assign bus.pix_data      = color_q;
  assign decompress_finish = (state_q == ST_DONE);
  assign busy              = (state_q != ST_IDLE);
  assign err_overrun       = ovr_q;
  assign err_budget        = bud_q;

endmodule

// File: tb/tb_rle_decompress.sv
// Directed bench for rle_decompress: three instances cover the uniform,
// backpressure, overrun, budget and start/reset scenarios.
module tb_rle_decompress;
  import fb_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic rst_a = 1'b0, start_a = 1'b0, fin_a, busy_a, ovr_a, bud_a;
  logic rst_b = 1'b0, start_b = 1'b0, fin_b, busy_b, ovr_b, bud_b;
  logic rst_c = 1'b0, start_c = 1'b0, fin_c, busy_c, ovr_c, bud_c;

  rle_decompress_if #(.ADDR_W(14)) bus_a ();
  rle_decompress_if #(.ADDR_W(14)) bus_b ();
  rle_decompress_if #(.ADDR_W(14)) bus_c ();

  rle_decompress #(.ADDR_W(14), .BASE_ADDR(0), .MAX_WORDS(16384), .FRAME_PIXELS(64)) u_a (
    .clock(clock), .reset_n(rst_a), .decompress_start(start_a), .decompress_finish(fin_a),
    .busy(busy_a), .bus(bus_a), .err_overrun(ovr_a), .err_budget(bud_a));
  rle_decompress #(.ADDR_W(14), .BASE_ADDR(0), .MAX_WORDS(16384), .FRAME_PIXELS(10)) u_b (
    .clock(clock), .reset_n(rst_b), .decompress_start(start_b), .decompress_finish(fin_b),
    .busy(busy_b), .bus(bus_b), .err_overrun(ovr_b), .err_budget(bud_b));
  rle_decompress #(.ADDR_W(14), .BASE_ADDR(0), .MAX_WORDS(2), .FRAME_PIXELS(100)) u_c (
    .clock(clock), .reset_n(rst_c), .decompress_start(start_c), .decompress_finish(fin_c),
    .busy(busy_c), .bus(bus_c), .err_overrun(ovr_c), .err_budget(bud_c));

  logic [15:0] mem_a [0:63];
  logic [15:0] mem_b [0:63];
  logic [15:0] mem_c [0:63];
  always @(posedge clock) if (bus_a.mem_rd) bus_a.mem_rdata <= mem_a[bus_a.mem_addr[5:0]];
  always @(posedge clock) if (bus_b.mem_rd) bus_b.mem_rdata <= mem_b[bus_b.mem_addr[5:0]];
  always @(posedge clock) if (bus_c.mem_rd) bus_c.mem_rdata <= mem_c[bus_c.mem_addr[5:0]];

  // Monitors sample on the falling edge, half a cycle from the DUT's edge.
  int unsigned reads_a = 0, fins_a = 0, stall_err_a = 0, last_xfer_a = 0;
  int unsigned reads_b = 0, fins_b = 0, last_xfer_b = 0;
  int unsigned reads_c = 0, fins_c = 0, last_xfer_c = 0, max_addr_c = 0;
  pixel_t q_a[$], q_b[$], q_c[$];
  logic   prev_stall_a = 1'b0;
  pixel_t prev_data_a  = '0;

  always @(negedge clock) begin
    if (bus_a.mem_rd) reads_a++;
    if (fin_a) fins_a++;
    if (bus_a.pix_valid && bus_a.pix_ready) begin
      q_a.push_back(bus_a.pix_data);
      last_xfer_a = cyc;
    end
    if (prev_stall_a && (!bus_a.pix_valid || bus_a.pix_data != prev_data_a)) stall_err_a++;
    prev_stall_a = bus_a.pix_valid && !bus_a.pix_ready;
    prev_data_a  = bus_a.pix_data;
  end

  always @(negedge clock) begin
    if (bus_b.mem_rd) reads_b++;
    if (fin_b) fins_b++;
    if (bus_b.pix_valid && bus_b.pix_ready) begin
      q_b.push_back(bus_b.pix_data);
      last_xfer_b = cyc;
    end
  end

  always @(negedge clock) begin
    if (bus_c.mem_rd) begin
      reads_c++;
      if (int'(bus_c.mem_addr) > max_addr_c) max_addr_c = int'(bus_c.mem_addr);
    end
    if (fin_c) fins_c++;
    if (bus_c.pix_valid && bus_c.pix_ready) begin
      q_c.push_back(bus_c.pix_data);
      last_xfer_c = cyc;
    end
  end

  task automatic pulse_start(input int sel, output int unsigned t);
    @(posedge clock); #1;
    if (sel == 0) start_a = 1'b1; else if (sel == 1) start_b = 1'b1; else start_c = 1'b1;
    t = cyc;
    @(posedge clock); #1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
  endtask

  task automatic wait_fin(input int sel, input int unsigned limit, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < limit; i++) begin
      @(negedge clock);
      if ((sel == 0 && fin_a) || (sel == 1 && fin_b) || (sel == 2 && fin_c)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    bus_a.pix_ready = 1'b0; bus_b.pix_ready = 1'b1; bus_c.pix_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    vectors++; if ({fin_a, busy_a, bus_a.mem_rd, bus_a.pix_valid} !== 4'b0000) begin
      $display("FAIL reset_ctrl: got %b, expected 0000", {fin_a, busy_a, bus_a.mem_rd, bus_a.pix_valid}); miscompares++; end
    vectors++; if (bus_a.mem_addr !== 14'd0) begin
      $display("FAIL reset_addr: got %0h, expected 0", bus_a.mem_addr); miscompares++; end
    vectors++; if (bus_a.pix_data !== 12'h000) begin
      $display("FAIL reset_data: got %0h, expected 0", bus_a.pix_data); miscompares++; end
    vectors++; if ({ovr_a, bud_a, busy_b, busy_c} !== 4'b0000) begin
      $display("FAIL reset_flags: got %b, expected 0000", {ovr_a, bud_a, busy_b, busy_c}); miscompares++; end
    @(posedge clock); #1;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
  endtask

  task automatic test_uniform();
    int unsigned t, base, r0, f0, bad;
    bit ok;
    for (int k = 0; k < 64; k++) mem_a[k] = (k < 4) ? 16'hF123 : 16'h0FFF;
    bus_a.pix_ready = 1'b1;
    base = q_a.size(); r0 = reads_a; f0 = fins_a;
    pulse_start(0, t);
    @(negedge clock);
    vectors++; if ({bus_a.mem_rd, busy_a, bus_a.mem_addr} !== {1'b1, 1'b1, 14'd0}) begin
      $display("FAIL uni_fetch_t1: got rd=%b busy=%b addr=%0h, expected 1 1 0", bus_a.mem_rd, busy_a, bus_a.mem_addr); miscompares++; end
    @(negedge clock);
    vectors++; if (bus_a.pix_valid !== 1'b0) begin
      $display("FAIL uni_valid_t2: got %b, expected 0", bus_a.pix_valid); miscompares++; end
    @(negedge clock);
    vectors++; if ({bus_a.pix_valid, bus_a.pix_data} !== {1'b1, 12'h123}) begin
      $display("FAIL uni_first_pix_t3: got v=%b d=%0h, expected 1 123", bus_a.pix_valid, bus_a.pix_data); miscompares++; end
    wait_fin(0, 300, ok);
    vectors++; if (!ok) begin
      $display("FAIL uni_finish_timeout: got none, expected finish pulse"); miscompares++; end
    vectors++; if (cyc !== last_xfer_a + 1 || busy_a !== 1'b1) begin
      $display("FAIL uni_finish_timing: got cyc=%0d busy=%b, expected cyc=%0d busy=1", cyc, busy_a, last_xfer_a + 1); miscompares++; end
    @(negedge clock);
    vectors++; if ({busy_a, fin_a} !== 2'b00) begin
      $display("FAIL uni_busy_drop: got %b, expected 00", {busy_a, fin_a}); miscompares++; end
    repeat (3) @(negedge clock);
    vectors++; if (q_a.size() - base !== 64) begin
      $display("FAIL uni_pix_count: got %0d, expected 64", q_a.size() - base); miscompares++; end
    bad = 0;
    for (int unsigned k = base; k < q_a.size(); k++) if (q_a[k] !== 12'h123) bad++;
    vectors++; if (bad !== 0) begin
      $display("FAIL uni_pix_value: got %0d wrong pixels, expected 0", bad); miscompares++; end
    vectors++; if (reads_a - r0 !== 4 || fins_a - f0 !== 1) begin
      $display("FAIL uni_reads_fins: got %0d/%0d, expected 4/1", reads_a - r0, fins_a - f0); miscompares++; end
    vectors++; if ({ovr_a, bud_a} !== 2'b00) begin
      $display("FAIL uni_errors: got %b, expected 00", {ovr_a, bud_a}); miscompares++; end
  endtask

  task automatic test_backpressure();
    logic [15:0] tbl [7] = '{16'h3ABC, 16'h0DEF, 16'hF456, 16'h7111, 16'hF222, 16'hE333, 16'h3444};
    pixel_t exp_q[$];
    int unsigned t, base, r0, f0, s0, bad;
    bit ok;
    for (int k = 0; k < 64; k++) mem_a[k] = (k < 7) ? tbl[k] : 16'h0FFF;
    foreach (tbl[k]) for (int j = 0; j <= int'(tbl[k][15:12]); j++) exp_q.push_back(tbl[k][11:0]);
    base = q_a.size(); r0 = reads_a; f0 = fins_a; s0 = stall_err_a;
    bus_a.pix_ready = 1'b0;
    pulse_start(0, t);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock); #1;
      bus_a.pix_ready = ($urandom_range(0, 9) < 3);
      @(negedge clock);
      if (fin_a) begin ok = 1'b1; break; end
    end
    bus_a.pix_ready = 1'b1;
    vectors++; if (!ok) begin
      $display("FAIL bp_finish_timeout: got none, expected finish pulse"); miscompares++; end
    repeat (4) @(negedge clock);
    vectors++; if (q_a.size() - base !== 64) begin
      $display("FAIL bp_pix_count: got %0d, expected 64", q_a.size() - base); miscompares++; end
    bad = 0;
    for (int unsigned k = 0; k < 64 && base + k < q_a.size(); k++) if (q_a[base + k] !== exp_q[k]) bad++;
    vectors++; if (bad !== 0) begin
      $display("FAIL bp_sequence: got %0d wrong pixels, expected 0", bad); miscompares++; end
    vectors++; if (stall_err_a - s0 !== 0) begin
      $display("FAIL bp_stall_stable: got %0d unstable stalls, expected 0", stall_err_a - s0); miscompares++; end
    vectors++; if (reads_a - r0 !== 7 || fins_a - f0 !== 1) begin
      $display("FAIL bp_reads_fins: got %0d/%0d, expected 7/1", reads_a - r0, fins_a - f0); miscompares++; end
  endtask

  task automatic test_overrun();
    int unsigned t, base, r0, f0, bad;
    bit ok;
    for (int k = 0; k < 64; k++) mem_b[k] = 16'h0FFF;
    mem_b[0] = 16'h7AAA; mem_b[1] = 16'h7BBB; mem_b[2] = 16'h7CCC;
    for (int run = 0; run < 2; run++) begin
      base = q_b.size(); r0 = reads_b; f0 = fins_b;
      pulse_start(1, t);
      @(negedge clock);
      if (run == 1) begin
        vectors++; if (ovr_b !== 1'b0) begin
          $display("FAIL ovr_cleared_on_start: got %b, expected 0", ovr_b); miscompares++; end
      end
      wait_fin(1, 100, ok);
      vectors++; if (!ok || {ovr_b, bud_b} !== 2'b10 || cyc !== last_xfer_b + 1) begin
        $display("FAIL ovr_finish_flags: got ok=%b ovr=%b bud=%b cyc=%0d, expected 1 1 0 %0d", ok, ovr_b, bud_b, cyc, last_xfer_b + 1); miscompares++; end
      repeat (3) @(negedge clock);
      vectors++; if (q_b.size() - base !== 10) begin
        $display("FAIL ovr_pix_count: got %0d, expected 10", q_b.size() - base); miscompares++; end
      bad = 0;
      for (int unsigned k = 0; k < 10 && base + k < q_b.size(); k++)
        if (q_b[base + k] !== ((k < 8) ? 12'hAAA : 12'hBBB)) bad++;
      vectors++; if (bad !== 0) begin
        $display("FAIL ovr_sequence: got %0d wrong pixels, expected 0", bad); miscompares++; end
      vectors++; if (reads_b - r0 !== 2 || fins_b - f0 !== 1) begin
        $display("FAIL ovr_reads_fins: got %0d/%0d, expected 2/1", reads_b - r0, fins_b - f0); miscompares++; end
    end
  endtask

  task automatic test_budget();
    int unsigned t, base, r0, f0;
    bit ok;
    for (int k = 0; k < 64; k++) mem_c[k] = 16'h0FFF;
    mem_c[0] = 16'h0111; mem_c[1] = 16'h0222; mem_c[2] = 16'h0333;
    base = q_c.size(); r0 = reads_c; f0 = fins_c;
    pulse_start(2, t);
    wait_fin(2, 100, ok);
    vectors++; if (!ok || {bud_c, ovr_c} !== 2'b10 || cyc !== last_xfer_c + 1) begin
      $display("FAIL bud_finish_flags: got ok=%b bud=%b ovr=%b, expected 1 1 0", ok, bud_c, ovr_c); miscompares++; end
    repeat (4) @(negedge clock);
    vectors++; if (q_c.size() - base !== 2) begin
      $display("FAIL bud_pix_count: got %0d, expected 2", q_c.size() - base); miscompares++; end
    vectors++; if (q_c.size() - base >= 2 && {q_c[base], q_c[base + 1]} !== {12'h111, 12'h222}) begin
      $display("FAIL bud_sequence: got %0h %0h, expected 111 222", q_c[base], q_c[base + 1]); miscompares++; end
    vectors++; if (reads_c - r0 !== 2 || max_addr_c !== 1 || fins_c - f0 !== 1) begin
      $display("FAIL bud_reads: got reads=%0d maxaddr=%0d fins=%0d, expected 2 1 1", reads_c - r0, max_addr_c, fins_c - f0); miscompares++; end
  endtask

  task automatic test_start_busy_reset();
    int unsigned t, base, r0, f0, n, bad;
    bit ok, sent;
    for (int k = 0; k < 64; k++) mem_a[k] = 16'h0FFF;
    mem_a[0] = 16'hF111; mem_a[1] = 16'hF222; mem_a[2] = 16'hF333; mem_a[3] = 16'hF444;
    bus_a.pix_ready = 1'b1;
    base = q_a.size(); r0 = reads_a; f0 = fins_a;
    pulse_start(0, t);
    n = 0; sent = 1'b0; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (bus_a.pix_valid && bus_a.pix_ready) n++;
      if (start_a) start_a = 1'b0;
      if (n == 5 && !sent) begin start_a = 1'b1; sent = 1'b1; end
      if (n == 20) begin rst_a = 1'b0; ok = 1'b1; break; end
    end
    vectors++; if (!ok) begin
      $display("FAIL sbr_reach_pixel20: got %0d pixels, expected 20", n); miscompares++; end
    @(negedge clock);
    vectors++; if ({bus_a.pix_valid, busy_a} !== 2'b00) begin
      $display("FAIL sbr_reset_idle: got %b, expected 00", {bus_a.pix_valid, busy_a}); miscompares++; end
    bad = 0;
    repeat (3) begin
      @(negedge clock);
      if (bus_a.mem_rd || fin_a || bus_a.pix_valid) bad++;
    end
    vectors++; if (bad !== 0 || fins_a - f0 !== 0 || reads_a - r0 !== 2) begin
      $display("FAIL sbr_quiet_after_reset: got bad=%0d fins=%0d reads=%0d, expected 0 0 2", bad, fins_a - f0, reads_a - r0); miscompares++; end
    bad = 0;
    for (int unsigned k = 0; k < 20 && base + k < q_a.size(); k++)
      if (q_a[base + k] !== ((k < 16) ? 12'h111 : 12'h222)) bad++;
    vectors++; if (bad !== 0 || q_a.size() - base !== 20) begin
      $display("FAIL sbr_partial_seq: got %0d wrong of %0d, expected 0 of 20", bad, q_a.size() - base); miscompares++; end
    @(posedge clock); #1;
    rst_a = 1'b1;
    base = q_a.size(); r0 = reads_a;
    pulse_start(0, t);
    @(negedge clock);
    vectors++; if ({bus_a.mem_rd, bus_a.mem_addr} !== {1'b1, 14'd0}) begin
      $display("FAIL sbr_restart_addr: got rd=%b addr=%0h, expected 1 0", bus_a.mem_rd, bus_a.mem_addr); miscompares++; end
    wait_fin(0, 300, ok);
    repeat (3) @(negedge clock);
    bad = 0;
    for (int unsigned k = 0; k < 64 && base + k < q_a.size(); k++)
      if (q_a[base + k] !== ((k < 16) ? 12'h111 : (k < 32) ? 12'h222 : (k < 48) ? 12'h333 : 12'h444)) bad++;
    vectors++; if (!ok || bad !== 0 || q_a.size() - base !== 64 || reads_a - r0 !== 4) begin
      $display("FAIL sbr_fresh_frame: got ok=%b bad=%0d pix=%0d reads=%0d, expected 1 0 64 4", ok, bad, q_a.size() - base, reads_a - r0); miscompares++; end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_backpressure();
    test_overrun();
    test_budget();
    test_start_busy_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
